// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param
//   Parametrised image-buffer controller. After reset the whole IMG_W x IMG_H
//   frame is streamed in from IROM, then host commands act on a 2x2 window
//   anchored at operation point (x,y); command 0 streams the frame out to IRB.
//
//   Window: P0=(x-1,y-1) P1=(x,y-1) P2=(x-1,y) P3=(x,y), x in 1..IMG_W-1,
//   y in 1..IMG_H-1. Pixel address = row*IMG_W + col.
//
//   Optional feature macro: LCD_CTRL_ROTATE_EN
//     defined   -> cmd 13 rotates the window clockwise, cmd 14 counter-clockwise
//     undefined -> cmds 13/14 are NOPs and no rotate logic exists
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   IROM_Q     in   IROM read data, valid one cycle after IROM_A
//   cmd        in   command code
//   cmd_valid  in   command qualifier, only sampled while busy=0
//   IROM_EN    out  IROM read enable, active low
//   IROM_A     out  IROM address
//   IRB_RW     out  IRB 0=write, 1=read/idle
//   IRB_D      out  IRB write data (buffer[IRB_A])
//   IRB_A      out  IRB address
//   busy       out  1 = commands not accepted
//   done       out  1 = frame write-back complete, held until next accepted cmd
module lcd_ctrl_param #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = $clog2(IMG_W*IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] IROM_Q,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [DW-1:0] IRB_D,
    output logic [AW-1:0] IRB_A,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = AW - XW;

    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_MID = XW'(IMG_W / 2);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_MID = YW'(IMG_H / 2);
    localparam logic [DW-1:0] PMAX  = '1;
    localparam logic [DW-1:0] QTR   = DW'(2 ** (DW - 2));
    localparam logic [DW-1:0] HALF  = DW'(2 ** (DW - 1));

    typedef enum logic [1:0] {
        S_LOAD,
        S_IDLE,
        S_EXEC,
        S_WRITE
    } state_e;

    typedef enum logic [3:0] {
        C_WRITE  = 4'd0,
        C_UP     = 4'd1,
        C_DOWN   = 4'd2,
        C_LEFT   = 4'd3,
        C_RIGHT  = 4'd4,
        C_AVG    = 4'd5,
        C_MIRX   = 4'd6,
        C_MIRY   = 4'd7,
        C_CENTER = 4'd8,
        C_ENH    = 4'd9,
        C_RED    = 4'd10,
        C_THR    = 4'd11,
        C_ITHR   = 4'd12,
        C_ROTCW  = 4'd13,
        C_ROTCCW = 4'd14
    } cmd_e;

    state_e        state_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [3:0]    cmd_q;
    logic          irom_en_q;
    logic [AW-1:0] irom_a_q;
    logic          irb_rw_q;
    logic [AW-1:0] irb_a_q;
    logic          busy_q;
    logic          done_q;
    // Load pipeline: address issued last cycle, whose data is on IROM_Q now.
    logic          ld_vld_q;
    logic [AW-1:0] ld_addr_q;
    logic          ld_issued_q;

    logic [DW-1:0] buf_q [N];

    logic [AW-1:0] wa    [4];
    logic [DW-1:0] win   [4];
    logic [DW-1:0] win_d [4];
    logic [DW+1:0] sum;

    function automatic logic [DW-1:0] px_enh(input logic [DW-1:0] p);
        logic [DW:0] s;
        s = {1'b0, p} + {1'b0, QTR};
        return s[DW] ? PMAX : s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] px_red(input logic [DW-1:0] p);
        return (p > QTR) ? (p - QTR) : '0;
    endfunction

    // Window addresses: IMG_W is a power of two, so row*IMG_W+col is {row,col}.
    always_comb begin
        wa[0] = {y_q - YW'(1), x_q - XW'(1)};
        wa[1] = {y_q - YW'(1), x_q};
        wa[2] = {y_q, x_q - XW'(1)};
        wa[3] = {y_q, x_q};
        for (int unsigned i = 0; i < 4; i++) begin
            win[i] = buf_q[wa[i]];
        end
    end

    // New window contents for the command in cmd_q; every read is of the
    // pre-update window so swaps and rotations are simultaneous.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum      = sum + {2'b00, win[i]};
            win_d[i] = win[i];
        end
        case (cmd_q)
            C_AVG: begin
                for (int unsigned i = 0; i < 4; i++) win_d[i] = sum[DW+1:2];
            end
            C_MIRX: begin
                win_d[0] = win[2];
                win_d[1] = win[3];
                win_d[2] = win[0];
                win_d[3] = win[1];
            end
            C_MIRY: begin
                win_d[0] = win[1];
                win_d[1] = win[0];
                win_d[2] = win[3];
                win_d[3] = win[2];
            end
            C_ENH: begin
                for (int unsigned i = 0; i < 4; i++) win_d[i] = px_enh(win[i]);
            end
            C_RED: begin
                for (int unsigned i = 0; i < 4; i++) win_d[i] = px_red(win[i]);
            end
            C_THR: begin
                for (int unsigned i = 0; i < 4; i++) win_d[i] = (win[i] > HALF) ? PMAX : '0;
            end
            C_ITHR: begin
                for (int unsigned i = 0; i < 4; i++) win_d[i] = (win[i] > HALF) ? '0 : PMAX;
            end
`ifdef LCD_CTRL_ROTATE_EN
            C_ROTCW: begin
                win_d[0] = win[2];
                win_d[1] = win[0];
                win_d[3] = win[1];
                win_d[2] = win[3];
            end
            C_ROTCCW: begin
                win_d[2] = win[0];
                win_d[0] = win[1];
                win_d[1] = win[3];
                win_d[3] = win[2];
            end
`endif
            default: ;
        endcase
    end

    // Frame buffer: no reset, contents survive until the next load.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && ld_vld_q) begin
            buf_q[ld_addr_q] <= IROM_Q;
        end else if (state_q == S_EXEC) begin
            for (int unsigned i = 0; i < 4; i++) buf_q[wa[i]] <= win_d[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD;
            x_q         <= X_MID;
            y_q         <= Y_MID;
            cmd_q       <= '0;
            irom_en_q   <= 1'b1;
            irom_a_q    <= '0;
            irb_rw_q    <= 1'b1;
            irb_a_q     <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            ld_vld_q    <= 1'b0;
            ld_addr_q   <= '0;
            ld_issued_q <= 1'b0;
        end else begin
            ld_vld_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    ld_vld_q  <= ~irom_en_q;
                    ld_addr_q <= irom_a_q;
                    if (!irom_en_q) begin
                        if (irom_a_q == LAST) begin
                            irom_en_q   <= 1'b1;
                            irom_a_q    <= '0;
                            ld_issued_q <= 1'b1;
                        end else begin
                            irom_a_q <= irom_a_q + AW'(1);
                        end
                    end else if (!ld_issued_q) begin
                        irom_en_q <= 1'b0;
                    end
                    // Leave once the final pixel lands in the buffer.
                    if (ld_vld_q && ld_addr_q == LAST) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        ld_issued_q <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q  <= cmd;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        if (cmd == C_WRITE) begin
                            state_q  <= S_WRITE;
                            irb_rw_q <= 1'b0;
                            irb_a_q  <= '0;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    case (cmd_q)
                        C_UP:     if (y_q > YW'(1)) y_q <= y_q - YW'(1);
                        C_DOWN:   if (y_q < Y_MAX)  y_q <= y_q + YW'(1);
                        C_LEFT:   if (x_q > XW'(1)) x_q <= x_q - XW'(1);
                        C_RIGHT:  if (x_q < X_MAX)  x_q <= x_q + XW'(1);
                        C_CENTER: begin
                            x_q <= X_MID;
                            y_q <= Y_MID;
                        end
                        default: ;
                    endcase
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_WRITE: begin
                    if (irb_a_q == LAST) begin
                        irb_rw_q <= 1'b1;
                        irb_a_q  <= '0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        irb_a_q <= irb_a_q + AW'(1);
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign IROM_EN = irom_en_q;
    assign IROM_A  = irom_a_q;
    assign IRB_RW  = irb_rw_q;
    assign IRB_A   = irb_a_q;
    assign IRB_D   = buf_q[irb_a_q];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
module tb_lcd_ctrl_param;

    localparam int N = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Instance A: DW=8, 8x8
    logic       rst_a, cv_a, en_a, rw_a, busy_a, done_a;
    logic [3:0] cmd_a_i;
    logic [7:0] q_a, irbd_a;
    logic [5:0] ia_a, irba_a;
    logic [7:0] mem_a [N];
    logic [7:0] got_a [N];

    lcd_ctrl_param #(.DW(8), .IMG_W(8), .IMG_H(8)) dut_a (
        .clk(clk), .reset(rst_a), .IROM_Q(q_a), .cmd(cmd_a_i), .cmd_valid(cv_a),
        .IROM_EN(en_a), .IROM_A(ia_a), .IRB_RW(rw_a), .IRB_D(irbd_a),
        .IRB_A(irba_a), .busy(busy_a), .done(done_a)
    );

    always @(posedge clk) if (en_a === 1'b0) q_a <= mem_a[ia_a];

    // Instance B: DW=10, 16x4
    logic       rst_b, cv_b, en_b, rw_b, busy_b, done_b;
    logic [3:0] cmd_b_i;
    logic [9:0] q_b, irbd_b;
    logic [5:0] ia_b, irba_b;
    logic [9:0] mem_b [N];
    logic [9:0] got_b [N];

    lcd_ctrl_param #(.DW(10), .IMG_W(16), .IMG_H(4)) dut_b (
        .clk(clk), .reset(rst_b), .IROM_Q(q_b), .cmd(cmd_b_i), .cmd_valid(cv_b),
        .IROM_EN(en_b), .IROM_A(ia_b), .IRB_RW(rw_b), .IRB_D(irbd_b),
        .IRB_A(irba_b), .busy(busy_b), .done(done_b)
    );

    always @(posedge clk) if (en_b === 1'b0) q_b <= mem_b[ia_b];

    task automatic set_base_a();
        for (int i = 0; i < N; i++) mem_a[i] = 8'(i);
    endtask

    // Issue one command on A once it is idle; returns #1 after the accept edge.
    task automatic cmd_a(input logic [3:0] c);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (busy_a === 1'b0) ok = 1'b1;
        end
        total++;
        if (!ok) $display("FAIL cmd_a_wait_idle cmd=%0d busy=%b expected 0", c, busy_a);
        else passed++;
        cmd_a_i = c;
        cv_a    = 1'b1;
        @(posedge clk);
        #1;
        cv_a = 1'b0;
    endtask

    // Follow the load after reset release on A, checking address order and timing.
    task automatic load_a();
        int en_n, busy_n, ord;
        bit fin;
        en_n = 0; busy_n = 0; ord = 0; fin = 1'b0;
        for (int i = 0; i < 300 && !fin; i++) begin
            @(posedge clk);
            #1;
            if (en_a === 1'b0) begin
                if (int'(ia_a) != en_n) ord++;
                en_n++;
            end
            if (busy_a === 1'b0) fin = 1'b1;
            else busy_n++;
        end
        total++;
        if (en_n != 64) $display("FAIL load_en_cycles got=%0d expected=64", en_n); else passed++;
        total++;
        if (busy_n != 65) $display("FAIL load_busy_cycles got=%0d expected=65", busy_n); else passed++;
        total++;
        if (ord != 0) $display("FAIL load_addr_order bad=%0d expected=0", ord); else passed++;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        load_a();
    endtask

    task automatic write_a(output int wn, output int ord);
        bit fin;
        wn = 0; ord = 0; fin = 1'b0;
        for (int i = 0; i < N; i++) got_a[i] = 'x;
        cmd_a(4'd0);
        for (int i = 0; i < 200 && !fin; i++) begin
            if (done_a === 1'b1) fin = 1'b1;
            else begin
                if (rw_a === 1'b0) begin
                    if (int'(irba_a) != wn) ord++;
                    got_a[irba_a] = irbd_a;
                    wn++;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst_a = 1'b1;
        @(negedge clk);
        obs = {en_a, ia_a, rw_a, irba_a, busy_a, done_a};
        total++;
        if (obs !== {1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0})
            $display("FAIL reset_outputs got=%b expected=%b", obs, {1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0});
        else passed++;
        @(negedge clk);
        rst_a = 1'b0;
        load_a();
    endtask

    task automatic test_write_frame();
        int wn, ord, errs;
        write_a(wn, ord);
        total++;
        if (wn != 64) $display("FAIL write_cycles got=%0d expected=64", wn); else passed++;
        total++;
        if (ord != 0) $display("FAIL write_addr_order bad=%0d expected=0", ord); else passed++;
        errs = 0;
        for (int i = 0; i < N; i++) if (got_a[i] !== 8'(i)) errs++;
        total++;
        if (errs != 0) $display("FAIL write_frame_data bad_pixels=%0d expected=0", errs); else passed++;
        total++;
        if ({done_a, busy_a, rw_a, irba_a} !== {1'b1, 1'b0, 1'b1, 6'd0})
            $display("FAIL write_end_state got=%b expected=%b", {done_a, busy_a, rw_a, irba_a}, {1'b1, 1'b0, 1'b1, 6'd0});
        else passed++;
    endtask

    task automatic test_done_hold();
        repeat (3) @(negedge clk);
        total++;
        if (done_a !== 1'b1) $display("FAIL done_held got=%b expected=1", done_a); else passed++;
        cmd_a(4'd8);
        total++;
        if ({done_a, busy_a} !== 2'b01) $display("FAIL done_clear got=%b expected=01", {done_a, busy_a}); else passed++;
        repeat (3) @(negedge clk);
        total++;
        if ({done_a, busy_a} !== 2'b00) $display("FAIL done_stays_clear got=%b expected=00", {done_a, busy_a}); else passed++;
    endtask

    // x: 4 -> 1 (saturated), y: 4 -> 3, avg; then x -> 7, y -> 7 (saturated), avg; centre, avg.
    task automatic test_move_avg();
        int wn, ord, errs;
        logic [7:0] exp [N];
        set_base_a();
        reset_a();
        repeat (5) cmd_a(4'd3);
        cmd_a(4'd1);
        cmd_a(4'd5);
        repeat (8) cmd_a(4'd4);
        repeat (5) cmd_a(4'd2);
        cmd_a(4'd5);
        cmd_a(4'd8);
        cmd_a(4'd5);
        write_a(wn, ord);
        for (int i = 0; i < N; i++) exp[i] = 8'(i);
        exp[16] = 8'd20; exp[17] = 8'd20; exp[24] = 8'd20; exp[25] = 8'd20;
        exp[54] = 8'd58; exp[55] = 8'd58; exp[62] = 8'd58; exp[63] = 8'd58;
        exp[27] = 8'd31; exp[28] = 8'd31; exp[35] = 8'd31; exp[36] = 8'd31;
        total++;
        if (got_a[16] !== 8'd20) $display("FAIL avg_left_sat got=%0d expected=20", got_a[16]); else passed++;
        total++;
        if (got_a[63] !== 8'd58) $display("FAIL avg_corner_sat got=%0d expected=58", got_a[63]); else passed++;
        total++;
        if (got_a[36] !== 8'd31) $display("FAIL avg_centre got=%0d expected=31", got_a[36]); else passed++;
        errs = 0;
        for (int i = 0; i < N; i++) if (got_a[i] !== exp[i]) errs++;
        total++;
        if (errs != 0) $display("FAIL move_avg_frame bad_pixels=%0d expected=0", errs); else passed++;
    endtask

    task automatic test_pixel_ops();
        int wn, ord, errs;
        logic [7:0] exp [N];
        logic [5:0] wad [4] = '{6'd27, 6'd28, 6'd35, 6'd36};
        logic [3:0] oc  [4] = '{4'd9, 4'd10, 4'd11, 4'd12};
        logic [7:0] ov  [4][4] = '{'{8'd255, 8'd74, 8'd128, 8'd193},
                                   '{8'd186, 8'd0,  8'd0,   8'd65 },
                                   '{8'd255, 8'd0,  8'd0,   8'd255},
                                   '{8'd0,   8'd255, 8'd255, 8'd0 }};
        set_base_a();
        mem_a[27] = 8'd250; mem_a[28] = 8'd10; mem_a[35] = 8'd64; mem_a[36] = 8'd129;
        for (int t = 0; t < 4; t++) begin
            reset_a();
            cmd_a(oc[t]);
            write_a(wn, ord);
            for (int i = 0; i < N; i++) exp[i] = mem_a[i];
            for (int k = 0; k < 4; k++) begin
                exp[wad[k]] = ov[t][k];
                total++;
                if (got_a[wad[k]] !== ov[t][k])
                    $display("FAIL op%0d_p%0d got=%0d expected=%0d", oc[t], k, got_a[wad[k]], ov[t][k]);
                else passed++;
            end
            errs = 0;
            for (int i = 0; i < N; i++) if (got_a[i] !== exp[i]) errs++;
            total++;
            if (errs != 0) $display("FAIL op%0d_frame bad_pixels=%0d expected=0", oc[t], errs); else passed++;
        end
    endtask

    task automatic test_mirror_rotate();
        int wn, ord;
        logic [5:0] wad [4] = '{6'd27, 6'd28, 6'd35, 6'd36};
        logic [3:0] oc  [5] = '{4'd6, 4'd7, 4'd13, 4'd14, 4'd15};
`ifdef LCD_CTRL_ROTATE_EN
        logic [7:0] ov  [5][4] = '{'{8'd3, 8'd4, 8'd1, 8'd2}, '{8'd2, 8'd1, 8'd4, 8'd3},
                                   '{8'd3, 8'd1, 8'd4, 8'd2}, '{8'd2, 8'd4, 8'd1, 8'd3},
                                   '{8'd1, 8'd2, 8'd3, 8'd4}};
`else
        logic [7:0] ov  [5][4] = '{'{8'd3, 8'd4, 8'd1, 8'd2}, '{8'd2, 8'd1, 8'd4, 8'd3},
                                   '{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd1, 8'd2, 8'd3, 8'd4},
                                   '{8'd1, 8'd2, 8'd3, 8'd4}};
`endif
        set_base_a();
        mem_a[27] = 8'd1; mem_a[28] = 8'd2; mem_a[35] = 8'd3; mem_a[36] = 8'd4;
        for (int t = 0; t < 5; t++) begin
            reset_a();
            cmd_a(oc[t]);
            write_a(wn, ord);
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got_a[wad[k]] !== ov[t][k])
                    $display("FAIL swap%0d_p%0d got=%0d expected=%0d", oc[t], k, got_a[wad[k]], ov[t][k]);
                else passed++;
            end
        end
    endtask

    // cmd_valid held high with cmd=1 for four edges: two accepts, y 4 -> 2.
    task automatic test_held_valid();
        int wn, ord, acc;
        bit ok;
        set_base_a();
        reset_a();
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (busy_a === 1'b0) ok = 1'b1;
        end
        acc = 0;
        cmd_a_i = 4'd1;
        cv_a    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (busy_a === 1'b0) acc++;
            @(posedge clk);
            @(negedge clk);
        end
        cv_a = 1'b0;
        total++;
        if (acc != 2) $display("FAIL held_valid_accepts got=%0d expected=2", acc); else passed++;
        cmd_a(4'd5);
        write_a(wn, ord);
        total++;
        if ({got_a[11], got_a[12], got_a[19], got_a[20]} !== {4{8'd15}})
            $display("FAIL held_valid_window got=%0d,%0d,%0d,%0d expected=15,15,15,15",
                     got_a[11], got_a[12], got_a[19], got_a[20]);
        else passed++;
    endtask

    task automatic test_reset_mid_write();
        int wn, ord, errs;
        bit found;
        set_base_a();
        reset_a();
        cmd_a(4'd0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (rw_a === 1'b0 && irba_a === 6'd30) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        total++;
        if (!found) $display("FAIL midwrite_reach_addr30 got=%0d expected=30", irba_a); else passed++;
        rst_a = 1'b1;
        #1;
        total++;
        if ({rw_a, irba_a, done_a, busy_a, en_a} !== {1'b1, 6'd0, 1'b0, 1'b1, 1'b1})
            $display("FAIL midwrite_abort got=%b expected=%b", {rw_a, irba_a, done_a, busy_a, en_a},
                     {1'b1, 6'd0, 1'b0, 1'b1, 1'b1});
        else passed++;
        @(negedge clk);
        rst_a = 1'b0;
        load_a();
        write_a(wn, ord);
        errs = 0;
        for (int i = 0; i < N; i++) if (got_a[i] !== 8'(i)) errs++;
        total++;
        if (errs != 0 || wn != 64) $display("FAIL midwrite_reload_frame bad_pixels=%0d writes=%0d expected=0,64", errs, wn);
        else passed++;
    endtask

    task automatic cmd_b(input logic [3:0] c);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (busy_b === 1'b0) ok = 1'b1;
        end
        total++;
        if (!ok) $display("FAIL cmd_b_wait_idle cmd=%0d busy=%b expected 0", c, busy_b);
        else passed++;
        cmd_b_i = c;
        cv_b    = 1'b1;
        @(posedge clk);
        #1;
        cv_b = 1'b0;
    endtask

    // DW=10, 16x4: x=8,y=2 at reset; cmd10 on 300 -> 44; y saturates at 3.
    task automatic test_wide();
        int en_n, busy_n, wn, errs;
        bit fin;
        logic [9:0] exp [N];
        for (int i = 0; i < N; i++) mem_b[i] = 10'(i);
        mem_b[23] = 10'd300;
        @(negedge clk);
        rst_b = 1'b0;
        en_n = 0; busy_n = 0; fin = 1'b0;
        for (int i = 0; i < 300 && !fin; i++) begin
            @(posedge clk);
            #1;
            if (en_b === 1'b0) en_n++;
            if (busy_b === 1'b0) fin = 1'b1;
            else busy_n++;
        end
        total++;
        if (en_n != 64 || busy_n != 65)
            $display("FAIL wide_load got=%0d,%0d expected=64,65", en_n, busy_n);
        else passed++;
        cmd_b(4'd10);
        repeat (9) cmd_b(4'd2);
        cmd_b(4'd5);
        for (int i = 0; i < N; i++) got_b[i] = 'x;
        cmd_b(4'd0);
        wn = 0; fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            if (done_b === 1'b1) fin = 1'b1;
            else begin
                if (rw_b === 1'b0) begin
                    got_b[irba_b] = irbd_b;
                    wn++;
                end
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < N; i++) exp[i] = 10'(i);
        exp[23] = 10'd44; exp[24] = 10'd0;
        exp[39] = 10'd27; exp[40] = 10'd27; exp[55] = 10'd27; exp[56] = 10'd27;
        total++;
        if (got_b[23] !== 10'd44) $display("FAIL wide_reduce got=%0d expected=44", got_b[23]); else passed++;
        total++;
        if (got_b[55] !== 10'd27) $display("FAIL wide_down_sat_avg got=%0d expected=27", got_b[55]); else passed++;
        errs = 0;
        for (int i = 0; i < N; i++) if (got_b[i] !== exp[i]) errs++;
        total++;
        if (errs != 0 || wn != 64) $display("FAIL wide_frame bad_pixels=%0d writes=%0d expected=0,64", errs, wn);
        else passed++;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        cv_a = 1'b0; cv_b = 1'b0;
        cmd_a_i = 4'd0; cmd_b_i = 4'd0;
        set_base_a();
        test_reset();
        test_write_frame();
        test_done_hold();
        test_move_avg();
        test_pixel_ops();
        test_mirror_rotate();
        test_held_valid();
        test_reset_mid_write();
        test_wide();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
